// File: rtl/fib_main.sv
// fib_main: iterative fib(n, a, b) accumulator; one-cycle start request, one-cycle done strobe.
module fib_main #(
  parameter int N_W = 6,
  parameter int D_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r_enable,
  input  logic           controlArr,
  input  logic [N_W-1:0] init_n_t_a,
  input  logic [D_W-1:0] init_a_t_a,
  input  logic [D_W-1:0] init_b_t_a,
  output logic           w_enable,
  output logic [D_W-1:0] result
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [N_W-1:0] n, n_nx;
  logic [D_W-1:0] a, a_nx, b, b_nx, result_nx;
  logic w_nx;
  logic start;
  assign start = r_enable && !controlArr;
  always_comb begin
    state_nx = state;
    n_nx = n;
    a_nx = a;
    b_nx = b;
    result_nx = result;
    w_nx = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        n_nx = init_n_t_a;
        a_nx = init_a_t_a;
        b_nx = init_b_t_a;
        state_nx = RUN;
      end
    end else if (n != '0) begin
      n_nx = n - 1'b1;
      a_nx = a + b;
      b_nx = a;
    end else begin
      result_nx = a;
      w_nx = 1'b1;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      a <= '0;
      b <= '0;
      result <= '0;
      w_enable <= 1'b0;
    end else begin
      state <= state_nx;
      n <= n_nx;
      a <= a_nx;
      b <= b_nx;
      result <= result_nx;
      w_enable <= w_nx;
    end
  end
endmodule

// File: tb/tb_fib_main.sv
// tb_fib_main: table-driven directed checks of fib_main plus multi-cycle corner sequences.
module tb_fib_main;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_enable = 1'b0;
  logic controlArr = 1'b0;
  logic [5:0] init_n_t_a = '0;
  logic [31:0] init_a_t_a = '0;
  logic [31:0] init_b_t_a = '0;
  logic w_enable;
  logic [31:0] result;
  int errors = 0;
  int checks = 0;

  fib_main #(.N_W(6), .D_W(32)) dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .controlArr(controlArr),
    .init_n_t_a(init_n_t_a), .init_a_t_a(init_a_t_a), .init_b_t_a(init_b_t_a),
    .w_enable(w_enable), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
    init_n_t_a = n;
    init_a_t_a = a;
    init_b_t_a = b;
    r_enable = 1'b1;
    tick();
    r_enable = 1'b0;
  endtask

  // Counts edges after the start edge until w_enable is seen; -1 on timeout.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (w_enable) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t vt[7];
    int k, pulses;
    vt[0] = '{6'd40, 32'd1, 32'd0, 32'd165580141, 41};
    vt[1] = '{6'd0, 32'd1, 32'd0, 32'd1, 1};
    vt[2] = '{6'd2, 32'd5, 32'd3, 32'd13, 3};
    vt[3] = '{6'd63, 32'd1, 32'd0, 32'd1640636603, 64};
    vt[4] = '{6'd1, 32'd7, 32'd9, 32'd16, 2};
    vt[5] = '{6'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 2};
    vt[6] = '{6'd5, 32'd0, 32'd0, 32'd0, 6};
    tick();
    tick();
    rst = 1'b0;
    check("reset_w_enable", w_enable, 0);
    check("reset_result", result, 0);

    foreach (vt[i]) begin
      start(vt[i].n, vt[i].a, vt[i].b);
      wait_done(k);
      check($sformatf("vec%0d_latency", i), k, vt[i].lat);
      check($sformatf("vec%0d_result", i), result, vt[i].exp);
      tick();
      check($sformatf("vec%0d_strobe_fall", i), w_enable, 0);
      check($sformatf("vec%0d_result_held", i), result, vt[i].exp);
    end

    // Start request and input changes during a run are ignored.
    start(6'd40, 32'd1, 32'd0);
    pulses = 0;
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        init_n_t_a = 6'd0;
        init_a_t_a = 32'd99;
        init_b_t_a = 32'd77;
        r_enable = 1'b1;
      end
      if (i == 6) r_enable = 1'b0;
      if (i == 12) init_a_t_a = 32'd1234;
      tick();
      if (w_enable) begin
        pulses++;
        if (k < 0) k = i;
      end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_latency", k, 41);
    check("ignore_result", result, 165580141);

    // Reset mid-run aborts with no strobe and clears result.
    start(6'd40, 32'd1, 32'd0);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_result", result, 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (w_enable) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_result_after", result, 0);

    // Override blocks the start request.
    controlArr = 1'b1;
    start(6'd0, 32'd5, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (w_enable) pulses++;
    end
    controlArr = 1'b0;
    check("override_pulses", pulses, 0);
    check("override_result", result, 0);

    // r_enable held high: n=0 runs alternate start/done, strobing every other edge.
    init_n_t_a = 6'd0;
    init_a_t_a = 32'd3;
    init_b_t_a = 32'd0;
    r_enable = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("held_w_edge%0d", i), w_enable, (i % 2 == 0) ? 1 : 0);
      if (w_enable) pulses++;
    end
    r_enable = 1'b0;
    check("held_pulses", pulses, 4);
    check("held_result", result, 3);
    tick();
    check("held_final_fall", w_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fib_main.md
Name: fib_main

Overview:
- Iterative Fibonacci-style accumulator core: sequential equivalent of the tail-recursive function fib(n, a, b).
  - fib returns a when n == 0.
  - Otherwise it returns fib(n-1, a+b, a).
- Started by a one-cycle request; raises a one-cycle completion strobe with the 32-bit result.
- Top-level compute block of the generated design, driven directly by a host/testbench.

Parameters:
- N_W, 6, width of iteration count input.
- D_W, 32, width of data operands and result.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- r_enable  input  1  start request; sampled on rising clk edge.
- controlArr  input  1  external array/control override; when 1, start requests are ignored (no internal arrays in this block).
- init_n_t_a  input  N_W  iteration count n.
- init_a_t_a  input  D_W  initial accumulator a.
- init_b_t_a  input  D_W  initial previous value b.
- w_enable  output  1  one-cycle done strobe.
- result  output  D_W  final value of a; valid from the cycle w_enable is high.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, w_enable=0, result=0, internal n/a/b=0.
  - Reset mid-operation aborts the computation; no w_enable is produced.
- States: IDLE, RUN.
- IDLE:
  - Condition: posedge with r_enable=1 and controlArr=0.
  - Action: load n<=init_n_t_a, a<=init_a_t_a, b<=init_b_t_a; go to RUN.
  - Otherwise stay in IDLE.
- RUN, n != 0: n<=n-1, a<=a+b, b<=a (all updated simultaneously from old values); stay in RUN.
- RUN, n == 0: result<=a, w_enable<=1, go to IDLE.
- w_enable:
  - High for exactly one cycle after each completion; otherwise 0.
  - A new start may be accepted in the same edge that w_enable falls.
- Latency: w_enable is high after the (n+1)-th rising edge following the start edge.
  - n=0: after 1 edge.
  - n=40: after 41 edges.
- result is held until the next completion or reset.
  - It is not cleared at start.
- r_enable is ignored while in RUN; inputs are sampled only at the start edge.
  - Later changes to the init_* inputs have no effect on a running computation.
- r_enable held high continuously: a new run starts on each IDLE cycle.
- Arithmetic: a+b is unsigned, modulo 2^D_W; overflow wraps silently.
- With a=1, b=0 the result is F(n+1), where F(1)=F(2)=1.

Test Plan:
- Reset, then n=40, a=1, b=0, r_enable pulsed for one posedge -> w_enable pulses once, 41 cycles after the start edge; result=165580141.
- n=0, a=1, b=0 -> w_enable one cycle after start; result=1.
- n=2, a=5, b=3 -> result=13 after 3 cycles.
- n=63, a=1, b=0 -> result=1640636603 (F(64) mod 2^32), 64 cycles after the start edge.
- During a run with n=40: a second r_enable pulse with n=0, plus toggling init_* -> ignored; result=165580141; only one w_enable pulse.
- Abort and override cases:
  - rst asserted at cycle 10 of the n=40 run -> no w_enable; result=0.
  - controlArr=1 with an r_enable pulse -> no start, w_enable stays 0.
